// File: rtl/qsgmii_hsst_rx_rst_seq.sv
// qsgmii_hsst_rx_rst_seq
// RX-lane reset sequencer for the HSST receiver. Walks the lane through
// power-up, PMA reset, CDR acquisition, PCS reset and word alignment, and
// re-enters the sequence whenever PLL lock, signal detect, CDR lock or
// alignment is lost. Timeouts in the CDR and alignment phases are counted
// in a saturating retry counter for debug.
//
// All lane controls are registered and decoded from the next state, so the
// outputs always describe the state currently held in the state register.
// Inputs are expected to be debounced and synchronous to clk already.
module qsgmii_hsst_rx_rst_seq #(
  parameter int unsigned           CNTR_WIDTH    = 16,
  parameter logic [CNTR_WIDTH-1:0] PMA_RST_HOLD  = 16'd64,
  parameter logic [CNTR_WIDTH-1:0] CDR_TIMEOUT   = 16'd8192,
  parameter logic [CNTR_WIDTH-1:0] PCS_RST_HOLD  = 16'd32,
  parameter logic [CNTR_WIDTH-1:0] ALIGN_TIMEOUT = 16'd4096,
  parameter int unsigned           RETRY_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pll_lock_deb,
  input  logic                   sigdet_deb,
  input  logic                   cdr_lock_deb,
  input  logic                   word_align_ok,
  output logic                   rx_lane_pd,
  output logic                   rx_pma_rst,
  output logic                   rx_pcs_rst,
  output logic                   rx_rst_done,
  output logic [2:0]             fsm_state,
  output logic [RETRY_WIDTH-1:0] retry_cnt
);

  // Sequencer states; codes 6 and 7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PMA_RST    = 3'd1,
    ST_WAIT_CDR   = 3'd2,
    ST_PCS_RST    = 3'd3,
    ST_WAIT_ALIGN = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  // Last timer value of each timed phase: a phase lasting N cycles leaves
  // when the timer (cleared on entry) reads N-1.
  localparam logic [CNTR_WIDTH-1:0] PMA_LAST   = PMA_RST_HOLD  - CNTR_WIDTH'(1);
  localparam logic [CNTR_WIDTH-1:0] CDR_LAST   = CDR_TIMEOUT   - CNTR_WIDTH'(1);
  localparam logic [CNTR_WIDTH-1:0] PCS_LAST   = PCS_RST_HOLD  - CNTR_WIDTH'(1);
  localparam logic [CNTR_WIDTH-1:0] ALIGN_LAST = ALIGN_TIMEOUT - CNTR_WIDTH'(1);

  state_t                  state_q;
  state_t                  state_d;
  logic [CNTR_WIDTH-1:0]   timer_q;
  logic [RETRY_WIDTH-1:0]  retry_q;
  logic                    retry_inc;
  logic                    lane_ok;

  // Lane-level decoded controls for the next state.
  logic                    pd_d;
  logic                    pma_d;
  logic                    pcs_d;
  logic                    done_d;

  assign lane_ok = sigdet_deb & cdr_lock_deb;

  // Next-state selection; loss of PLL lock overrides every other condition.
  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    if (!pll_lock_deb) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PMA_RST;
        end
        ST_PMA_RST: begin
          if (timer_q == PMA_LAST) begin
            state_d = ST_WAIT_CDR;
          end
        end
        ST_WAIT_CDR: begin
          // Lock is checked before the timeout so a simultaneous lock wins
          // and does not count as a retry.
          if (lane_ok) begin
            state_d = ST_PCS_RST;
          end else if (timer_q == CDR_LAST) begin
            state_d   = ST_PMA_RST;
            retry_inc = 1'b1;
          end
        end
        ST_PCS_RST: begin
          if (timer_q == PCS_LAST) begin
            state_d = ST_WAIT_ALIGN;
          end
        end
        ST_WAIT_ALIGN: begin
          if (!lane_ok) begin
            state_d = ST_PMA_RST;
          end else if (word_align_ok) begin
            state_d = ST_DONE;
          end else if (timer_q == ALIGN_LAST) begin
            state_d   = ST_PCS_RST;
            retry_inc = 1'b1;
          end
        end
        ST_DONE: begin
          // Loss exits restart a phase but are not timeouts, so no retry.
          if (!lane_ok) begin
            state_d = ST_PMA_RST;
          end else if (!word_align_ok) begin
            state_d = ST_PCS_RST;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Moore decode of the lane controls for the state about to be entered.
  always_comb begin
    pd_d   = 1'b1;
    pma_d  = 1'b1;
    pcs_d  = 1'b1;
    done_d = 1'b0;
    case (state_d)
      ST_PMA_RST: begin
        pd_d = 1'b0;
      end
      ST_WAIT_CDR, ST_PCS_RST: begin
        pd_d  = 1'b0;
        pma_d = 1'b0;
      end
      ST_WAIT_ALIGN: begin
        pd_d  = 1'b0;
        pma_d = 1'b0;
        pcs_d = 1'b0;
      end
      ST_DONE: begin
        pd_d   = 1'b0;
        pma_d  = 1'b0;
        pcs_d  = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        pd_d   = 1'b1;
        pma_d  = 1'b1;
        pcs_d  = 1'b1;
        done_d = 1'b0;
      end
    endcase
  end

  // State, shared phase timer, retry counter and registered lane controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      retry_q     <= '0;
      rx_lane_pd  <= 1'b1;
      rx_pma_rst  <= 1'b1;
      rx_pcs_rst  <= 1'b1;
      rx_rst_done <= 1'b0;
    end else begin
      state_q <= state_d;

      // Each phase times itself from zero; the timer parks at all-ones.
      if (state_d != state_q) begin
        timer_q <= '0;
      end else if (timer_q != '1) begin
        timer_q <= timer_q + CNTR_WIDTH'(1);
      end

      // Returning to IDLE starts a fresh bring-up, so the history is dropped.
      if (state_d == ST_IDLE) begin
        retry_q <= '0;
      end else if (retry_inc && (retry_q != '1)) begin
        retry_q <= retry_q + RETRY_WIDTH'(1);
      end

      rx_lane_pd  <= pd_d;
      rx_pma_rst  <= pma_d;
      rx_pcs_rst  <= pcs_d;
      rx_rst_done <= done_d;
    end
  end

  assign fsm_state = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_qsgmii_hsst_rx_rst_seq.sv
// Bench for qsgmii_hsst_rx_rst_seq with shortened phase lengths.
// A phase-level reference model predicts state, lane controls and retry
// count one cycle ahead; predictions go through an expected queue and are
// compared on the falling edge after each rising edge.
module tb_qsgmii_hsst_rx_rst_seq;

  localparam int PMA_N   = 8;
  localparam int CDR_N   = 32;
  localparam int PCS_N   = 4;
  localparam int ALIGN_N = 16;
  localparam int RMAX    = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_lock_deb = 1'b0;
  logic sigdet_deb = 1'b0;
  logic cdr_lock_deb = 1'b0;
  logic word_align_ok = 1'b0;
  logic rx_lane_pd;
  logic rx_pma_rst;
  logic rx_pcs_rst;
  logic rx_rst_done;
  logic [2:0] fsm_state;
  logic [3:0] retry_cnt;

  always #5 clk = ~clk;

  qsgmii_hsst_rx_rst_seq #(
    .CNTR_WIDTH   (16),
    .PMA_RST_HOLD (16'd8),
    .CDR_TIMEOUT  (16'd32),
    .PCS_RST_HOLD (16'd4),
    .ALIGN_TIMEOUT(16'd16),
    .RETRY_WIDTH  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock_deb (pll_lock_deb),
    .sigdet_deb   (sigdet_deb),
    .cdr_lock_deb (cdr_lock_deb),
    .word_align_ok(word_align_ok),
    .rx_lane_pd   (rx_lane_pd),
    .rx_pma_rst   (rx_pma_rst),
    .rx_pcs_rst   (rx_pcs_rst),
    .rx_rst_done  (rx_rst_done),
    .fsm_state    (fsm_state),
    .retry_cnt    (retry_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [10:0] exp_q[$];
  int cnt_pma = 0;
  int cnt_pcs = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase numbers: 0 idle, 1 pma reset, 2 wait cdr, 3 pcs reset,
  // 4 wait align, 5 done. m_time counts cycles spent in the phase so far.
  int m_state = 0;
  int m_time  = 0;
  int m_retry = 0;

  task automatic model_reset();
    m_state = 0;
    m_time  = 0;
    m_retry = 0;
  endtask

  // Lane controls as a function of phase: power-down only while idle, PMA
  // reset through the PMA phase, PCS reset through the PCS phase, done last.
  function automatic logic [3:0] exp_outs(input int ph);
    logic pd, pma, pcs, done;
    pd   = (ph == 0);
    pma  = (ph <= 1);
    pcs  = (ph <= 3);
    done = (ph == 5);
    return {pd, pma, pcs, done};
  endfunction

  task automatic model_step(input bit pll, input bit sig, input bit cdr, input bit wa);
    int  nxt;
    bit  timeout;
    bit  lane;
    nxt     = m_state;
    timeout = 0;
    lane    = sig && cdr;
    if (!pll) nxt = 0;
    else if (m_state == 0) nxt = 1;
    else if (m_state == 1) begin
      if (m_time + 1 == PMA_N) nxt = 2;
    end else if (m_state == 2) begin
      if (lane) nxt = 3;
      else if (m_time + 1 == CDR_N) begin nxt = 1; timeout = 1; end
    end else if (m_state == 3) begin
      if (m_time + 1 == PCS_N) nxt = 4;
    end else if (m_state == 4) begin
      if (!lane) nxt = 1;
      else if (wa) nxt = 5;
      else if (m_time + 1 == ALIGN_N) begin nxt = 3; timeout = 1; end
    end else begin
      if (!lane) nxt = 1;
      else if (!wa) nxt = 3;
    end
    m_time  = (nxt == m_state) ? m_time + 1 : 0;
    m_state = nxt;
    if (nxt == 0) m_retry = 0;
    else if (timeout && m_retry < RMAX) m_retry = m_retry + 1;
  endtask

  // ---------------- driver ----------------
  // Called on a falling edge: drive inputs, predict, clock once, compare.
  task automatic step(input bit pll, input bit sig, input bit cdr, input bit wa);
    logic [10:0] e;
    pll_lock_deb  = pll;
    sigdet_deb    = sig;
    cdr_lock_deb  = cdr;
    word_align_ok = wa;
    model_step(pll, sig, cdr, wa);
    exp_q.push_back({3'(m_state), exp_outs(m_state), 4'(m_retry)});
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq("state", fsm_state, e[10:8]);
    check_eq("pd_pma_pcs_done", {rx_lane_pd, rx_pma_rst, rx_pcs_rst, rx_rst_done}, e[7:4]);
    check_eq("retry", retry_cnt, e[3:0]);
    if (rx_pma_rst && !rx_lane_pd) cnt_pma++;
    if (rx_pcs_rst) cnt_pcs++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    model_reset();
    pll_lock_deb = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_state", fsm_state, 0);
    check_eq("rst_outs", {rx_lane_pd, rx_pma_rst, rx_pcs_rst, rx_rst_done}, 4'b1110);
    check_eq("rst_retry", retry_cnt, 0);
    rst_n = 1'b1;

    // Nominal bring-up: lock at cycle 5 of WAIT_CDR, align 3 cycles in.
    cnt_pma = 0;
    for (k = 0; k < 60 && !(m_state == 2 && m_time == 5); k++) step(1, 0, 0, 0);
    check_eq("reach_cdr5", (m_state == 2 && m_time == 5), 1);
    check_eq("pma_len", cnt_pma, PMA_N);
    cnt_pcs = 0;
    step(1, 1, 1, 0);
    for (k = 0; k < 30 && !(m_state == 4 && m_time == 3); k++) step(1, 1, 1, 0);
    check_eq("reach_align3", (m_state == 4 && m_time == 3), 1);
    check_eq("pcs_len", cnt_pcs, PCS_N);
    step(1, 1, 1, 1);
    check_eq("done_rise", rx_rst_done, 1);
    check_eq("done_retry", retry_cnt, 0);

    // DONE with a one-cycle alignment drop: PCS reset for 4 cycles.
    cnt_pcs = 0;
    step(1, 1, 1, 0);
    for (k = 0; k < 20 && m_state != 4; k++) step(1, 1, 1, 1);
    check_eq("realign_pcs_len", cnt_pcs, PCS_N);
    step(1, 1, 1, 1);
    check_eq("redone", rx_rst_done, 1);

    // DONE with signal-detect loss: PMA reset on the next cycle.
    step(1, 0, 1, 1);
    check_eq("sigloss_pma", rx_pma_rst, 1);
    check_eq("sigloss_done", rx_rst_done, 0);

    // Alignment timeout once, then PLL loss in WAIT_ALIGN.
    for (k = 0; k < 40 && m_state != 4; k++) step(1, 1, 1, 0);
    for (k = 0; k < 40 && m_state != 3; k++) step(1, 1, 1, 0);
    check_eq("align_to_retry", retry_cnt, 1);
    for (k = 0; k < 40 && m_state != 4; k++) step(1, 1, 1, 0);
    check_eq("reach_align", m_state, 4);
    step(0, 1, 1, 0);
    check_eq("pll_loss_pd", rx_lane_pd, 1);
    check_eq("pll_loss_retry", retry_cnt, 0);

    // Lock arriving on the CDR timeout cycle: lock wins, no retry.
    for (k = 0; k < 60 && !(m_state == 2 && m_time == CDR_N - 1); k++) step(1, 0, 0, 0);
    check_eq("reach_cdr_last", (m_state == 2 && m_time == CDR_N - 1), 1);
    step(1, 1, 1, 0);
    check_eq("tie_state", fsm_state, 3);
    check_eq("tie_retry", retry_cnt, 0);

    // Asynchronous reset in the middle of PCS_RST.
    step(1, 1, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_outs", {rx_lane_pd, rx_pma_rst, rx_pcs_rst, rx_rst_done}, 4'b1110);
    check_eq("arst_state", fsm_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // CDR never locks: 17 timeouts saturate the retry counter.
    for (k = 0; k < 700; k++) step(1, 0, 0, 0);
    check_eq("retry_sat", retry_cnt, RMAX);

    // Random phase with rare PLL drops and frequent lane glitches.
    for (k = 0; k < 3000; k++) begin
      step($urandom_range(299, 0) != 0,
           $urandom_range(15, 0) != 0,
           $urandom_range(15, 0) != 0,
           $urandom_range(3, 0) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/qsgmii_hsst_rx_rst_seq.md
Name: qsgmii_hsst_rx_rst_seq

Overview:
- RX-lane reset sequencer that drives the HSST receive PMA and PCS resets.
- Consumes the debounced PLL-lock, signal-detect and CDR-lock status returned by the lane, plus word-align status. It walks the lane through power-up, PMA reset, CDR acquisition, PCS reset and alignment, and re-enters the sequence on loss events.
- Sits between the lane status debouncers and the HSST RX reset pins. It is the initiator whose results those debouncers qualify.

Parameters:
- CNTR_WIDTH, 16, width of the shared state timer.
- PMA_RST_HOLD, 16'd64, number of cycles rx_pma_rst is held in PMA_RST (must be ≥1).
- CDR_TIMEOUT, 16'd8192, number of cycles allowed in WAIT_CDR before a retry.
- PCS_RST_HOLD, 16'd32, number of cycles rx_pcs_rst is held in PCS_RST (must be ≥1).
- ALIGN_TIMEOUT, 16'd4096, number of cycles allowed in WAIT_ALIGN before a PCS retry.
- RETRY_WIDTH, 4, width of the saturating retry counter.

Ports:
- clk  input  1  sequencer clock (free-running).
- rst_n  input  1  asynchronous active-low reset.
- pll_lock_deb  input  1  debounced PLL lock; high means locked.
- sigdet_deb  input  1  debounced RX signal detect; high means a signal is present.
- cdr_lock_deb  input  1  debounced CDR lock; high means locked.
- word_align_ok  input  1  PCS word alignment achieved (synchronous to clk).
- rx_lane_pd  output  1  RX lane power-down, active high.
- rx_pma_rst  output  1  RX PMA reset, active high.
- rx_pcs_rst  output  1  RX PCS reset, active high.
- rx_rst_done  output  1  lane ready; high only in DONE.
- fsm_state  output  3  current state encoding, for debug.
- retry_cnt  output  RETRY_WIDTH  count of CDR and align timeouts, saturating.

Behaviour:
- Reset (rst_n low) values:
  - state = IDLE, timer = 0, retry_cnt = 0.
  - rx_lane_pd = 1, rx_pma_rst = 1, rx_pcs_rst = 1, rx_rst_done = 0.
- All outputs are registered and reflect the current state in the same cycle the state register holds it (Moore outputs, decoded from next-state).
- State encodings (fsm_state) and outputs per state:
  - IDLE = 3'd0: pd = 1, pma = 1, pcs = 1, done = 0.
  - PMA_RST = 3'd1: pd = 0, pma = 1, pcs = 1, done = 0.
  - WAIT_CDR = 3'd2: pd = 0, pma = 0, pcs = 1, done = 0.
  - PCS_RST = 3'd3: pd = 0, pma = 0, pcs = 1, done = 0.
  - WAIT_ALIGN = 3'd4: pd = 0, pma = 0, pcs = 0, done = 0.
  - DONE = 3'd5: pd = 0, pma = 0, pcs = 0, done = 1.
  - Codes 6 and 7 are unused and go to IDLE on the next cycle.
- Timer rules:
  - The timer clears to 0 on every state change.
  - Otherwise it increments by 1 each cycle and saturates at all-ones.
- Transitions, highest priority first:
  1. pll_lock_deb == 0 in any state → IDLE.
  2. IDLE: pll_lock_deb == 1 → PMA_RST.
  3. PMA_RST: timer == PMA_RST_HOLD-1 → WAIT_CDR. The state is occupied exactly PMA_RST_HOLD cycles.
  4. WAIT_CDR:
     - sigdet_deb && cdr_lock_deb → PCS_RST.
     - Else if timer == CDR_TIMEOUT-1 → PMA_RST and retry_cnt +1.
     - Lock and timeout in the same cycle: lock wins, and retry_cnt is not incremented.
  5. PCS_RST: timer == PCS_RST_HOLD-1 → WAIT_ALIGN.
  6. WAIT_ALIGN:
     - sigdet_deb == 0 or cdr_lock_deb == 0 → PMA_RST.
     - Else if word_align_ok → DONE.
     - Else if timer == ALIGN_TIMEOUT-1 → PCS_RST and retry_cnt +1.
  7. DONE:
     - sigdet_deb == 0 or cdr_lock_deb == 0 → PMA_RST.
     - Else if word_align_ok == 0 → PCS_RST.
     - No retry increment on either exit.
- retry_cnt:
  - Saturates at 2^RETRY_WIDTH-1.
  - Cleared only by rst_n and by entry to IDLE.
- Assertion of rst_n low mid-sequence forces the reset values asynchronously. After release, the sequence restarts from IDLE and no stale timer value is carried.
- Inputs are assumed already synchronous to clk; no synchronizers in this block.

Test Plan:
- Params PMA=8, CDR_TO=32, PCS=4, ALIGN_TO=16. Release rst_n with pll_lock_deb=1; raise sigdet/cdr at cycle 5 of WAIT_CDR and word_align_ok 3 cycles into WAIT_ALIGN.
  → rx_pma_rst high for exactly 8 cycles after IDLE and rx_pcs_rst falls 4 cycles after PCS_RST entry.
  → rx_rst_done rises 1 cycle after word_align_ok, with retry_cnt = 0.
- cdr_lock_deb held 0 → WAIT_CDR exits at timer 31 back to PMA_RST; after 17 timeouts retry_cnt holds 4'hF.
- cdr_lock_deb rising on the same cycle timer == 31 → next state PCS_RST, retry_cnt unchanged.
- In DONE, drop word_align_ok for 1 cycle → PCS_RST, rx_pcs_rst = 1 for 4 cycles, then WAIT_ALIGN.
- In DONE, drop sigdet_deb → PMA_RST, rx_pma_rst = 1 and rx_rst_done = 0 on the next cycle.
- In WAIT_ALIGN, drop pll_lock_deb → IDLE with rx_lane_pd = 1 and retry_cnt = 0.
- Pulse rst_n low mid-PCS_RST → outputs return to reset values immediately (pd/pma/pcs = 1, done = 0) without waiting for a clock edge.
